// File: rtl/axil_apb_pkg.sv
// Shared types and constants for the AXI4-Lite to APB bridge.
// FSM state encoding and AXI response codes.
package axil_apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } st_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite.sv
// AXI4-Lite bundle with slave and master views.
// aclk/aresetn are carried for the interconnect only.
interface axi4_Lite #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic                aclk;
  logic                aresetn;
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport axiSlave (
    input  aclk, aresetn,
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

  modport axiMaster (
    output aclk, aresetn,
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

endinterface

// File: rtl/axil_apb_decode.sv
// Address decode: slave index field plus miss detection
// for bits above the field or an index past NUM_SLV.
module axil_apb_decode
  import axil_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SLV_AW  = 12,
  parameter int IW      = $clog2(NUM_SLV)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IW-1:0]     idx,
  output logic              miss
);

  logic upper;
  logic unused_lo;

  assign idx       = addr[SLV_AW +: IW];
  assign unused_lo = ^addr[SLV_AW-1:0];

  if (SLV_AW + IW < ADDR_W) begin : g_hi
    assign upper = |addr[ADDR_W-1:SLV_AW+IW];
  end else begin : g_nohi
    assign upper = 1'b0;
  end

  assign miss = upper | (32'(idx) >= NUM_SLV);

endmodule

// File: rtl/axil_apb_bridge.sv
// AXI4-Lite slave to multi-slave APB master bridge.
// Optional ACCESS watchdog enabled by APB_TIMEOUT_EN.
module axil_apb_bridge
  import axil_apb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_SLV     = 4,
  parameter int SLV_AW      = 12,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  axi4_Lite.axiSlave                axiS,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  output logic [DATA_W/8-1:0]       pstrb,
  output logic [2:0]                pprot,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  localparam int SW = DATA_W / 8;
  localparam int IW = $clog2(NUM_SLV);

  st_t state, state_d;

  logic              aw_full, w_full, ar_full;
  logic [ADDR_W-1:0] aw_addr, ar_addr;
  logic [2:0]        aw_prot, ar_prot;
  logic [DATA_W-1:0] w_data;
  logic [SW-1:0]     w_strb;

  logic aw_hs, w_hs, ar_hs;
  logic wr_pend, rd_pend, grant_wr;
  logic clr_wr, clr_rd;

  logic [ADDR_W-1:0] aw_a, ar_a, sel_addr;
  logic [2:0]        aw_p, ar_p;
  logic [DATA_W-1:0] w_d;
  logic [SW-1:0]     w_s;

  logic [IW-1:0] dec_idx;
  logic          dec_miss;

  logic              cur_wr, cur_wr_d;
  logic [IW-1:0]     cur_idx, idx_d;
  logic [1:0]        resp_q, resp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              prio_rd, prio_d;

  logic [NUM_SLV-1:0] psel_d;
  logic               penable_d, pwrite_d;
  logic [ADDR_W-1:0]  paddr_d;
  logic [DATA_W-1:0]  pwdata_d;
  logic [SW-1:0]      pstrb_d;
  logic [2:0]         pprot_d;

  logic              pready_s, pslverr_s, tmo;
  logic [DATA_W-1:0] prdata_s;
  logic              unused_clk;

  assign unused_clk = axiS.aclk ^ axiS.aresetn;

  assign axiS.awready = ~aw_full & ~rst;
  assign axiS.wready  = ~w_full & ~rst;
  assign axiS.arready = ~ar_full & ~rst;

  assign aw_hs = axiS.awvalid & axiS.awready;
  assign w_hs  = axiS.wvalid & axiS.wready;
  assign ar_hs = axiS.arvalid & axiS.arready;

  // Requests completing this cycle are visible to IDLE
  assign aw_a = aw_full ? aw_addr : axiS.awaddr;
  assign aw_p = aw_full ? aw_prot : axiS.awprot;
  assign w_d  = w_full ? w_data : axiS.wdata;
  assign w_s  = w_full ? w_strb : axiS.wstrb;
  assign ar_a = ar_full ? ar_addr : axiS.araddr;
  assign ar_p = ar_full ? ar_prot : axiS.arprot;

  assign wr_pend  = (aw_full | aw_hs) & (w_full | w_hs);
  assign rd_pend  = ar_full | ar_hs;
  assign grant_wr = wr_pend & (~rd_pend | ~prio_rd);
  assign sel_addr = grant_wr ? aw_a : ar_a;

  axil_apb_decode #(
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV),
    .SLV_AW  (SLV_AW)
  ) u_dec (
    .addr (sel_addr),
    .idx  (dec_idx),
    .miss (dec_miss)
  );

  assign pready_s  = pready[cur_idx];
  assign pslverr_s = pslverr[cur_idx];
  assign prdata_s  = prdata[int'(cur_idx)*DATA_W +: DATA_W];

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || state != ACCESS) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

  assign tmo = (cnt == CW'(TIMEOUT_CYC - 1));
`else
  localparam int unused_tmo = TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    psel_d    = psel;
    penable_d = penable;
    pwrite_d  = pwrite;
    paddr_d   = paddr;
    pwdata_d  = pwdata;
    pstrb_d   = pstrb;
    pprot_d   = pprot;
    cur_wr_d  = cur_wr;
    idx_d     = cur_idx;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    prio_d    = prio_rd;
    clr_wr    = 1'b0;
    clr_rd    = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_pend | rd_pend) begin
          cur_wr_d = grant_wr;
          idx_d    = dec_idx;
          // pointer only moves when both directions contend
          if (wr_pend & rd_pend) prio_d = grant_wr;
          if (dec_miss) begin
            state_d = RESP;
            resp_d  = DECERR;
            rdata_d = '0;
          end else begin
            state_d         = SETUP;
            psel_d          = '0;
            psel_d[dec_idx] = 1'b1;
            pwrite_d        = grant_wr;
            paddr_d         = sel_addr;
            pwdata_d        = grant_wr ? w_d : '0;
            pstrb_d         = grant_wr ? w_s : '0;
            pprot_d         = grant_wr ? aw_p : ar_p;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready_s) begin
          state_d   = RESP;
          psel_d    = '0;
          penable_d = 1'b0;
          resp_d    = pslverr_s ? SLVERR : OKAY;
          rdata_d   = prdata_s;
        end else if (tmo) begin
          state_d   = RESP;
          psel_d    = '0;
          penable_d = 1'b0;
          resp_d    = SLVERR;
          rdata_d   = '0;
        end
      end
      RESP: begin
        if (cur_wr ? axiS.bready : axiS.rready) begin
          state_d = IDLE;
          clr_wr  = cur_wr;
          clr_rd  = ~cur_wr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psel    <= '0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      pprot   <= '0;
      cur_wr  <= 1'b0;
      cur_idx <= '0;
      resp_q  <= OKAY;
      rdata_q <= '0;
      prio_rd <= 1'b0;
    end else begin
      psel    <= psel_d;
      penable <= penable_d;
      pwrite  <= pwrite_d;
      paddr   <= paddr_d;
      pwdata  <= pwdata_d;
      pstrb   <= pstrb_d;
      pprot   <= pprot_d;
      cur_wr  <= cur_wr_d;
      cur_idx <= idx_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      prio_rd <= prio_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      ar_full <= 1'b0;
      aw_addr <= '0;
      aw_prot <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      ar_addr <= '0;
      ar_prot <= '0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= axiS.awaddr;
        aw_prot <= axiS.awprot;
      end else if (clr_wr) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= axiS.wdata;
        w_strb <= axiS.wstrb;
      end else if (clr_wr) begin
        w_full <= 1'b0;
      end
      if (ar_hs) begin
        ar_full <= 1'b1;
        ar_addr <= axiS.araddr;
        ar_prot <= axiS.arprot;
      end else if (clr_rd) begin
        ar_full <= 1'b0;
      end
    end
  end

  assign axiS.bvalid = (state == RESP) & cur_wr;
  assign axiS.rvalid = (state == RESP) & ~cur_wr;
  assign axiS.bresp  = resp_q;
  assign axiS.rresp  = resp_q;
  assign axiS.rdata  = rdata_q;

endmodule

// File: doc/axil_apb_bridge.md
# axil_apb_bridge

- Parametrised AXI4-Lite slave to multi-slave APB master bridge.
- Successor to the single-target AXI-Lite structure: adds address decode across `NUM_SLV` APB slaves, independent capture of write and read requests, and round-robin write/read arbitration.
- Maps APB `PSLVERR` to `SLVERR` and unmapped addresses to `DECERR`.
- Sits between the system AXI4-Lite interconnect and the peripheral APB segment.

## Interface
Parameters:
- `DATA_W`, 32: data width; `DATA_W/8` strobe bits.
- `ADDR_W`, 32: address width.
- `NUM_SLV`, 4: number of APB slaves, ≥ 2.
- `SLV_AW`, 12: log2 of each slave's window size in bytes.
- `TIMEOUT_CYC`, 255: ACCESS-phase watchdog limit. Used only with `APB_TIMEOUT_EN`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `axiS` interface `axi4_Lite.axiSlave`: all AW/W/B/AR/R channels. Its `aclk`/`aresetn` are unused; the block is clocked by `clk`/`rst` only.
- `psel` out `NUM_SLV`: one-hot slave select.
- `penable` out 1: APB access phase.
- `pwrite` out 1: 1 = write.
- `paddr` out `ADDR_W`: captured address.
- `pwdata` out `DATA_W`: write data.
- `pstrb` out `DATA_W/8`: write strobes. All zeros on reads.
- `pprot` out 3: from `awprot` or `arprot`.
- `prdata` in `NUM_SLV*DATA_W`: per-slave read data. Slave i occupies slice `[i*DATA_W +: DATA_W]`.
- `pready` in `NUM_SLV`: per-slave ready.
- `pslverr` in `NUM_SLV`: per-slave error.

## Operation
**Channel capture**
- AW, W and AR each have a holding register with a full flag.
- `awready`/`wready`/`arready` = 1 whenever the matching flag is clear, in any state. AW and W may arrive in either order or in the same cycle.
- A write request is pending once both AW and W are held. A read request is pending once AR is held.

**Arbitration**
- Evaluated in IDLE when a request is pending.
- If both write and read are pending, the direction not served last wins. After reset, write wins first.

**Decode**
- `idx = addr[SLV_AW +: $clog2(NUM_SLV)]`.
- Miss when any address bit above that field is nonzero, or when `idx ≥ NUM_SLV`.
- On a miss: no APB cycle, go straight to RESP with `DECERR` (2'b11).

**FSM** (`IDLE`, `SETUP`, `ACCESS`, `RESP`)
- IDLE → SETUP on a decoded hit; IDLE → RESP on a miss.
- SETUP: `psel[idx]`=1, `penable`=0, lasts exactly 1 cycle, then → ACCESS.
- ACCESS: `penable`=1, hold until `pready[idx]`. On that cycle:
  - capture the `prdata` slice;
  - response = `pslverr[idx]` ? `SLVERR` (2'b10) : `OKAY` (2'b00);
  - → RESP.
- RESP: assert `bvalid` or `rvalid`, held with stable `bresp`/`rresp`/`rdata` until `bready`/`rready`. Then clear that direction's holding flags and → IDLE.

**Data on errors**
- `rdata` = 0 on `DECERR`. On `SLVERR`, `rdata` is the sampled `prdata` slice.

**APB output stability**
- All APB outputs are registered and stable from SETUP through ACCESS.

**Reset**
- While `rst` is high: every output 0, including all ready signals; state IDLE; flags cleared; priority set to write.
- Reset mid-transfer drops `psel`/`penable` at the next edge and discards the in-flight response.

## Timing
- AW+W handshake at cycle 0 → SETUP at 1 → ACCESS at 2. If `pready` is high at 2, `bvalid` is high at 3.
- Minimum latency from request handshake to response valid: 3 cycles.
- `DECERR` response: valid 1 cycle after the request is complete.
- Back-to-back transfers: a response handshake in cycle n gives IDLE at n+1 and the next SETUP at n+2.
- AR accepted while a write is in flight is served immediately after the write's RESP completes.

## Configuration
- `APB_TIMEOUT_EN` defined:
  - an ACCESS-cycle counter runs while waiting for `pready`;
  - after `TIMEOUT_CYC` cycles without `pready`: drop `psel`/`penable`, respond `SLVERR`, `rdata` = 0.
- `APB_TIMEOUT_EN` undefined: no counter; ACCESS waits indefinitely.

## Structure
- Package `axil_apb_pkg`: FSM state enum and the response constants `OKAY`, `SLVERR`, `DECERR`.
- Sub-module `axil_apb_decode`: address → `idx` and miss flag, parametrised by `ADDR_W`, `NUM_SLV`, `SLV_AW`.

## Test plan
- **Basic write:** write 0x1004, data 0xDEADBEEF, strobes 0xF, slave 1 `pready` on first ACCESS cycle → `psel`=4'b0010, `pwdata`=0xDEADBEEF, `bresp`=0, `bvalid` at cycle 3.
- **Read with error:** read 0x3010, slave 3 returns 0x12345678 with `pslverr`=1 after 2 wait cycles → `rresp`=2'b10, `rdata`=0x12345678.
- **Unmapped address:** read 0x10000 → no `psel` activity, `rresp`=2'b11, `rdata`=0.
- **Arbitration:** AW, W and AR handshaken in the same cycle → write served first, read next; repeat → read served first on the second round.
- **W before AW:** W accepted 2 cycles before AW → exactly one APB write, `awready` remains 1 until AW is captured.
- **Timeout** (`APB_TIMEOUT_EN`, `TIMEOUT_CYC`=4): `pready` held at 0 → `psel` drops after 4 ACCESS cycles, `bresp`=2'b10. Also assert `rst` mid-ACCESS → all outputs 0 next cycle.
